// File: rtl/rob_pkg.sv
// Shared types and width constants for the reorder buffer slice.
// The entry struct widths follow the package defaults; rob_top parameters default to the same values.
package rob_pkg;

    localparam int ARCHFILE_SIZE_DEF = 32;
    localparam int PHYSFILE_SIZE_DEF = 256;
    localparam int ROB_SIZE_DEF      = 128;

    localparam int AW_DEF    = $clog2(ARCHFILE_SIZE_DEF);
    localparam int PW_DEF    = $clog2(PHYSFILE_SIZE_DEF);
    localparam int RW_DEF    = $clog2(ROB_SIZE_DEF);
    localparam int PTR_W_DEF = RW_DEF + 1;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic [AW_DEF-1:0] arch;
        logic [PW_DEF-1:0] phys;
        logic [PW_DEF-1:0] oldphys;
    } rob_entry_t;

endpackage

// File: rtl/rob_entry_array.sv
// ROB entry storage: one allocate write port, one done-set port, one retire-clear port,
// a combinational head read port and a whole-array flush of the valid/done flags.
module rob_entry_array
    import rob_pkg::*;
#(
    parameter int ROB_SIZE = ROB_SIZE_DEF,
    parameter int RW       = $clog2(ROB_SIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_flush,
    input  logic              i_wr_en,
    input  logic [RW-1:0]     i_wr_idx,
    input  logic [AW_DEF-1:0] i_wr_arch,
    input  logic [PW_DEF-1:0] i_wr_phys,
    input  logic [PW_DEF-1:0] i_wr_oldphys,
    input  logic              i_set_done,
    input  logic [RW-1:0]     i_done_idx,
    input  logic              i_clr_en,
    input  logic [RW-1:0]     i_clr_idx,
    input  logic [RW-1:0]     i_rd_idx,
    output rob_entry_t        o_rd_data
);

    logic [ROB_SIZE-1:0] r_valid;
    logic [ROB_SIZE-1:0] r_done;
    logic [AW_DEF-1:0]   r_arch    [ROB_SIZE];
    logic [PW_DEF-1:0]   r_phys    [ROB_SIZE];
    logic [PW_DEF-1:0]   r_oldphys [ROB_SIZE];

    // Valid/done flags; allocation is written last so a fresh entry always starts not-done.
    always_ff @(posedge clk) begin
        if (!rst || i_flush) begin
            r_valid <= '0;
            r_done  <= '0;
        end else begin
            if (i_set_done && r_valid[i_done_idx]) begin
                r_done[i_done_idx] <= 1'b1;
            end
            if (i_clr_en) begin
                r_valid[i_clr_idx] <= 1'b0;
                r_done[i_clr_idx]  <= 1'b0;
            end
            if (i_wr_en) begin
                r_valid[i_wr_idx] <= 1'b1;
                r_done[i_wr_idx]  <= 1'b0;
            end
        end
    end

    // Payload fields carry no reset; they are only observed while the valid flag is set.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_arch[i_wr_idx]    <= i_wr_arch;
            r_phys[i_wr_idx]    <= i_wr_phys;
            r_oldphys[i_wr_idx] <= i_wr_oldphys;
        end
    end

    // Head read port.
    always_comb begin
        o_rd_data         = '0;
        o_rd_data.valid   = r_valid[i_rd_idx];
        o_rd_data.done    = r_done[i_rd_idx];
        o_rd_data.arch    = r_arch[i_rd_idx];
        o_rd_data.phys    = r_phys[i_rd_idx];
        o_rd_data.oldphys = r_oldphys[i_rd_idx];
    end

endmodule

// File: rtl/rob_top.sv
// Reorder buffer: in-order allocate, out-of-order finish, in-order single retire per cycle,
// and a full flush on exception. Pointers carry an extra wrap bit to tell full from empty.
module rob_top
    import rob_pkg::*;
#(
    parameter int ARCHFILE_SIZE = ARCHFILE_SIZE_DEF,
    parameter int PHYSFILE_SIZE = PHYSFILE_SIZE_DEF,
    parameter int ROB_SIZE      = ROB_SIZE_DEF,
    localparam int AW           = $clog2(ARCHFILE_SIZE),
    localparam int PW           = $clog2(PHYSFILE_SIZE),
    localparam int RW           = $clog2(ROB_SIZE)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          uop_update,
    input  logic [AW-1:0] uop_dest_arch_in,
    input  logic [PW-1:0] uop_dest_phys_in,
    input  logic [PW-1:0] uop_dest_oldphys_in,
    input  logic          except,
    input  logic          uop_finish,
    input  logic [RW-1:0] uop_finish_rob_entry,
    output logic          retire_uop,
    output logic [AW-1:0] uop_dest_arch_out,
    output logic [PW-1:0] uop_dest_phys_out,
    output logic [PW-1:0] uop_dest_oldphys_out,
    output logic [RW-1:0] next_rob_entry,
    output logic          rob_full
);

    localparam logic [RW:0] PTR_ONE = (RW+1)'(1);

    logic [RW:0] r_head;
    logic [RW:0] r_tail;
    rob_entry_t  w_head_entry;
    logic        w_full;
    logic        w_empty;
    logic        w_alloc;
    logic        w_finish;
    logic        w_retire;

    assign w_full  = (r_head[RW-1:0] == r_tail[RW-1:0]) && (r_head[RW] != r_tail[RW]);
    assign w_empty = (r_head == r_tail);

    // Exception dominates: it suppresses every other state change in its cycle.
    always_comb begin
        w_alloc  = 1'b0;
        w_finish = 1'b0;
        w_retire = 1'b0;
        if (except) begin
            w_alloc  = 1'b0;
            w_finish = 1'b0;
            w_retire = 1'b0;
        end else begin
            w_alloc  = uop_update && !w_full;
            w_finish = uop_finish;
            w_retire = !w_empty && w_head_entry.valid && w_head_entry.done;
        end
    end

    // Head/tail pointers; natural overflow of the RW+1 bit pointer toggles the wrap bit.
    always_ff @(posedge clk) begin
        if (!rst || except) begin
            r_head <= '0;
            r_tail <= '0;
        end else begin
            if (w_alloc) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_retire) begin
                r_head <= r_head + PTR_ONE;
            end
        end
    end

    rob_entry_array #(
        .ROB_SIZE (ROB_SIZE),
        .RW       (RW)
    ) u_entries (
        .clk          (clk),
        .rst          (rst),
        .i_flush      (except),
        .i_wr_en      (w_alloc),
        .i_wr_idx     (r_tail[RW-1:0]),
        .i_wr_arch    (uop_dest_arch_in),
        .i_wr_phys    (uop_dest_phys_in),
        .i_wr_oldphys (uop_dest_oldphys_in),
        .i_set_done   (w_finish),
        .i_done_idx   (uop_finish_rob_entry),
        .i_clr_en     (w_retire),
        .i_clr_idx    (r_head[RW-1:0]),
        .i_rd_idx     (r_head[RW-1:0]),
        .o_rd_data    (w_head_entry)
    );

    // Retire port shows the head payload only while it retires.
    always_comb begin
        retire_uop           = w_retire;
        uop_dest_arch_out    = '0;
        uop_dest_phys_out    = '0;
        uop_dest_oldphys_out = '0;
        if (w_retire) begin
            uop_dest_arch_out    = w_head_entry.arch;
            uop_dest_phys_out    = w_head_entry.phys;
            uop_dest_oldphys_out = w_head_entry.oldphys;
        end else begin
            uop_dest_arch_out    = '0;
            uop_dest_phys_out    = '0;
            uop_dest_oldphys_out = '0;
        end
    end

    assign next_rob_entry = r_tail[RW-1:0];
    assign rob_full       = w_full;

endmodule

// File: tb/tb_rob_top.sv
// Self-checking bench for rob_top: per-scenario tasks plus an in-order retirement scoreboard.
module tb_rob_top;

    localparam int ROB = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       uop_update = 1'b0;
    logic [4:0] uop_dest_arch_in = 5'd0;
    logic [7:0] uop_dest_phys_in = 8'd0;
    logic [7:0] uop_dest_oldphys_in = 8'd0;
    logic       except = 1'b0;
    logic       uop_finish = 1'b0;
    logic [6:0] uop_finish_rob_entry = 7'd0;
    logic       retire_uop;
    logic [4:0] uop_dest_arch_out;
    logic [7:0] uop_dest_phys_out;
    logic [7:0] uop_dest_oldphys_out;
    logic [6:0] next_rob_entry;
    logic       rob_full;

    int          checks = 0;
    int          failures = 0;
    logic [20:0] sb_q[$];
    int          m_cnt = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;

    rob_top dut (
        .clk                  (clk),
        .rst                  (rst),
        .uop_update           (uop_update),
        .uop_dest_arch_in     (uop_dest_arch_in),
        .uop_dest_phys_in     (uop_dest_phys_in),
        .uop_dest_oldphys_in  (uop_dest_oldphys_in),
        .except               (except),
        .uop_finish           (uop_finish),
        .uop_finish_rob_entry (uop_finish_rob_entry),
        .retire_uop           (retire_uop),
        .uop_dest_arch_out    (uop_dest_arch_out),
        .uop_dest_phys_out    (uop_dest_phys_out),
        .uop_dest_oldphys_out (uop_dest_oldphys_out),
        .next_rob_entry       (next_rob_entry),
        .rob_full             (rob_full)
    );

    // Scoreboard: every observed retirement must match the oldest accepted allocation.
    always @(negedge clk) begin
        if (mon_en && rst === 1'b1) begin
            checks++;
            if (retire_uop === 1'b1) begin
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected_retire got=%h/%h/%h exp=none", uop_dest_arch_out, uop_dest_phys_out, uop_dest_oldphys_out);
                end else begin
                    logic [20:0] exp_e;
                    exp_e = sb_q.pop_front();
                    m_cnt--;
                    if ({uop_dest_arch_out, uop_dest_phys_out, uop_dest_oldphys_out} !== exp_e) begin
                        failures++;
                        $display("FAIL sb_retire_payload got=%h/%h/%h exp=%h/%h/%h", uop_dest_arch_out, uop_dest_phys_out,
                                 uop_dest_oldphys_out, exp_e[20:16], exp_e[15:8], exp_e[7:0]);
                    end
                end
            end else if (retire_uop === 1'b0) begin
                if ({uop_dest_arch_out, uop_dest_phys_out, uop_dest_oldphys_out} !== 21'd0) begin
                    failures++;
                    $display("FAIL sb_idle_outputs got=%h/%h/%h exp=0/0/0", uop_dest_arch_out, uop_dest_phys_out, uop_dest_oldphys_out);
                end
            end else begin
                failures++;
                $display("FAIL sb_retire_unknown got=%b exp=0_or_1", retire_uop);
            end
        end
    end

    task automatic clk_step();
        @(posedge clk);
        #1;
        uop_update = 1'b0;
        uop_finish = 1'b0;
        except     = 1'b0;
    endtask

    // Drives an allocation for the current cycle; it is expected only if not full and no flush.
    task automatic set_alloc(input logic [4:0] a, input logic [7:0] p, input logic [7:0] o);
        uop_update          = 1'b1;
        uop_dest_arch_in    = a;
        uop_dest_phys_in    = p;
        uop_dest_oldphys_in = o;
        if (!except && m_cnt < ROB) begin
            sb_q.push_back({a, p, o});
            m_cnt++;
        end
    endtask

    task automatic set_finish(input logic [6:0] idx);
        uop_finish           = 1'b1;
        uop_finish_rob_entry = idx;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        @(negedge clk);
        clk_step();
        rst = 1'b1;
        sb_q.delete();
        m_cnt = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        uop_update = 1'b1;
        uop_dest_arch_in = 5'h1F;
        uop_dest_phys_in = 8'hEE;
        uop_dest_oldphys_in = 8'hDD;
        uop_finish = 1'b1;
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL reset_retire got=%b exp=0", retire_uop); end
        checks++; if (next_rob_entry !== 7'd0) begin failures++; $display("FAIL reset_next got=%0d exp=0", next_rob_entry); end
        checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", rob_full); end
        checks++; if (uop_dest_arch_out !== 5'd0) begin failures++; $display("FAIL reset_arch got=%h exp=0", uop_dest_arch_out); end
        checks++; if (uop_dest_phys_out !== 8'd0) begin failures++; $display("FAIL reset_phys got=%h exp=0", uop_dest_phys_out); end
        checks++; if (uop_dest_oldphys_out !== 8'd0) begin failures++; $display("FAIL reset_old got=%h exp=0", uop_dest_oldphys_out); end
        rst = 1'b1;
        mon_en = 1'b1;
        clk_step();
    endtask

    task automatic test_alloc();
        logic [20:0] vals [5];
        vals[0] = {5'h05, 8'hAA, 8'hFF};
        vals[1] = {5'h0A, 8'hFF, 8'h55};
        vals[2] = {5'h0F, 8'h55, 8'h00};
        vals[3] = {5'h01, 8'h11, 8'h22};
        vals[4] = {5'h02, 8'h12, 8'h23};
        for (int i = 0; i < 5; i++) begin
            set_alloc(vals[i][20:16], vals[i][15:8], vals[i][7:0]);
            @(negedge clk);
            checks++; if (next_rob_entry !== 7'(i)) begin failures++; $display("FAIL alloc_next[%0d] got=%0d exp=%0d", i, next_rob_entry, i); end
            checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL alloc_no_retire[%0d] got=%b exp=0", i, retire_uop); end
            clk_step();
        end
        @(negedge clk);
        checks++; if (next_rob_entry !== 7'd5) begin failures++; $display("FAIL alloc_next_final got=%0d exp=5", next_rob_entry); end
        clk_step();
    endtask

    task automatic test_ooo_finish();
        set_finish(7'd1);
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL ooo_finish1_cycle got=%b exp=0", retire_uop); end
        clk_step();
        set_finish(7'd0);
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL ooo_after_finish1 got=%b exp=0", retire_uop); end
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b1) begin failures++; $display("FAIL ooo_retire0 got=%b exp=1", retire_uop); end
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b1) begin failures++; $display("FAIL ooo_retire1 got=%b exp=1", retire_uop); end
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL ooo_head2_waits got=%b exp=0", retire_uop); end
        checks++; if (next_rob_entry !== 7'd5) begin failures++; $display("FAIL ooo_next got=%0d exp=5", next_rob_entry); end
        clk_step();
    endtask

    task automatic test_full();
        do_reset();
        @(negedge clk);
        checks++; if (next_rob_entry !== 7'd0) begin failures++; $display("FAIL full_midreset_next got=%0d exp=0", next_rob_entry); end
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL full_midreset_retire got=%b exp=0", retire_uop); end
        clk_step();
        for (int i = 0; i < ROB; i++) begin
            set_alloc(5'($urandom_range(0, 31)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            @(negedge clk);
            if (i == ROB - 1) begin
                checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL full_at_127 got=%b exp=0", rob_full); end
                checks++; if (next_rob_entry !== 7'd127) begin failures++; $display("FAIL full_next_127 got=%0d exp=127", next_rob_entry); end
            end
            clk_step();
        end
        set_alloc(5'h13, 8'h99, 8'h88);
        @(negedge clk);
        checks++; if (rob_full !== 1'b1) begin failures++; $display("FAIL full_set got=%b exp=1", rob_full); end
        checks++; if (next_rob_entry !== 7'd0) begin failures++; $display("FAIL full_next_wrap got=%0d exp=0", next_rob_entry); end
        clk_step();
        set_finish(7'd0);
        @(negedge clk);
        checks++; if (next_rob_entry !== 7'd0) begin failures++; $display("FAIL full_drop_next got=%0d exp=0", next_rob_entry); end
        checks++; if (rob_full !== 1'b1) begin failures++; $display("FAIL full_still got=%b exp=1", rob_full); end
        clk_step();
        set_alloc(5'h14, 8'h98, 8'h87);
        @(negedge clk);
        checks++; if (retire_uop !== 1'b1) begin failures++; $display("FAIL full_retire0 got=%b exp=1", retire_uop); end
        checks++; if (rob_full !== 1'b1) begin failures++; $display("FAIL full_during_retire got=%b exp=1", rob_full); end
        clk_step();
        @(negedge clk);
        checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL full_cleared got=%b exp=0", rob_full); end
        checks++; if (next_rob_entry !== 7'd0) begin failures++; $display("FAIL full_tail_kept got=%0d exp=0", next_rob_entry); end
        clk_step();
    endtask

    task automatic test_except();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_alloc(5'(i + 1), 8'(8'h30 + i), 8'(8'h40 + i));
            @(negedge clk);
            clk_step();
        end
        set_finish(7'd0);
        @(negedge clk);
        clk_step();
        except = 1'b1;
        set_finish(7'd1);
        set_alloc(5'h1F, 8'h77, 8'h66);
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL except_no_retire got=%b exp=0", retire_uop); end
        clk_step();
        sb_q.delete();
        m_cnt = 0;
        @(negedge clk);
        checks++; if (next_rob_entry !== 7'd0) begin failures++; $display("FAIL except_next got=%0d exp=0", next_rob_entry); end
        checks++; if (rob_full !== 1'b0) begin failures++; $display("FAIL except_full got=%b exp=0", rob_full); end
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL except_after got=%b exp=0", retire_uop); end
        clk_step();
        for (int i = 1; i < 3; i++) begin
            set_finish(7'(i));
            @(negedge clk);
            clk_step();
        end
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL except_stale_finish got=%b exp=0", retire_uop); end
        clk_step();
        set_alloc(5'h1E, 8'h9A, 8'h9B);
        @(negedge clk);
        clk_step();
        set_finish(7'd0);
        @(negedge clk);
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b1) begin failures++; $display("FAIL except_new_retire got=%b exp=1", retire_uop); end
        clk_step();
    endtask

    task automatic test_simultaneous();
        do_reset();
        set_alloc(5'h03, 8'hA1, 8'hB1);
        @(negedge clk); clk_step();
        set_alloc(5'h04, 8'hA2, 8'hB2);
        @(negedge clk); clk_step();
        set_alloc(5'h06, 8'hA3, 8'hB3);
        @(negedge clk); clk_step();
        set_finish(7'd0);
        @(negedge clk); clk_step();
        set_alloc(5'h07, 8'hA4, 8'hB4);
        set_finish(7'd2);
        @(negedge clk);
        checks++; if (retire_uop !== 1'b1) begin failures++; $display("FAIL simul_retire_head got=%b exp=1", retire_uop); end
        clk_step();
        @(negedge clk);
        checks++; if (next_rob_entry !== 7'd4) begin failures++; $display("FAIL simul_tail got=%0d exp=4", next_rob_entry); end
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL simul_head1_waits got=%b exp=0", retire_uop); end
        clk_step();
        set_finish(7'd1);
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL simul_finish_head_same_cycle got=%b exp=0", retire_uop); end
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b1) begin failures++; $display("FAIL simul_retire1 got=%b exp=1", retire_uop); end
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b1) begin failures++; $display("FAIL simul_retire2 got=%b exp=1", retire_uop); end
        clk_step();
        @(negedge clk);
        checks++; if (retire_uop !== 1'b0) begin failures++; $display("FAIL simul_entry3_waits got=%b exp=0", retire_uop); end
        checks++; if (sb_q.size() != 1) begin failures++; $display("FAIL simul_pending got=%0d exp=1", sb_q.size()); end
        clk_step();
    endtask

    initial begin
        test_reset();
        test_alloc();
        test_ooo_finish();
        test_full();
        test_except();
        test_simultaneous();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
